// File: rtl/risc_pkg.sv
// Shared constants, opcode names, IR fetch-state encoding and the opcode one-hot decode helper
// for the instruction register slice.
package risc_pkg;

  localparam int DW          = 8;
  localparam int AW          = 13;
  localparam int IR_W        = 2 * DW;
  localparam int MAX_GAP_DEF = 6;
  localparam int HIST_DEPTH  = 4;

  typedef enum logic [2:0] {
    HLT  = 3'd0,
    SKZ  = 3'd1,
    ADD  = 3'd2,
    ANDD = 3'd3,
    XORR = 3'd4,
    LDA  = 3'd5,
    STO  = 3'd6,
    JMP  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } ir_state_e;

  function automatic logic [7:0] opc_decode(input logic [2:0] op);
    opc_decode = 8'h01 << op;
  endfunction

endpackage

// File: rtl/instr_reg_if.sv
// Bus between the controller/program memory (master) and the instruction register (slave).
interface instr_reg_if;
  import risc_pkg::*;

  logic            ena;
  logic            load_ir;
  logic [DW-1:0]   data;
  logic [2:0]      opcode;
  logic [AW-1:0]   ir_addr;
  logic [7:0]      opc_hot;
  logic            ir_valid;
  logic            frag_err;
  logic [1:0]      hist_sel;
  logic [IR_W-1:0] hist_data;

  modport master (
    output ena, load_ir, data, hist_sel,
    input  opcode, ir_addr, opc_hot, ir_valid, frag_err, hist_data
  );

  modport slave (
    input  ena, load_ir, data, hist_sel,
    output opcode, ir_addr, opc_hot, ir_valid, frag_err, hist_data
  );
endinterface

// File: rtl/instr_reg_hist.sv
// Shift-register history of committed instructions; entry 0 is the most recent,
// unwritten entries read zero. Used by instr_reg only when IR_HISTORY_EN is defined.
module ir_history_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] sel,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // History shift: reset clears all entries, each push shifts older entries down.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push) begin
      mem_r[0] <= wdata;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign rdata = mem_r[sel];

endmodule

// File: rtl/instr_reg.sv
// Instruction register: assembles high/low fetch bytes into a committed 16-bit instruction.
// Optional commit history is enabled by defining IR_HISTORY_EN.
module instr_reg
  import risc_pkg::*;
#(
  parameter int MAX_GAP = MAX_GAP_DEF
) (
  input logic        clk1,
  input logic        rst,
  instr_reg_if.slave bus
);

  localparam int GW = $clog2(MAX_GAP + 1);

  ir_state_e       state_r;
  logic [DW-1:0]   shadow_r;
  logic [IR_W-1:0] ir_r;
  logic [7:0]      opc_hot_r;
  logic            ir_valid_r;
  logic            frag_err_r;
  logic [GW-1:0]   gap_r;

  // Fetch FSM: ena low abandons a partial fetch but keeps the committed instruction.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      state_r    <= EMPTY;
      shadow_r   <= {DW{1'b0}};
      ir_r       <= 16'h0000;
      opc_hot_r  <= 8'h01;
      ir_valid_r <= 1'b0;
      frag_err_r <= 1'b0;
      gap_r      <= {GW{1'b0}};
    end else if (!bus.ena) begin
      state_r    <= EMPTY;
      ir_valid_r <= 1'b0;
      gap_r      <= {GW{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (bus.load_ir) begin
            shadow_r <= bus.data;
            state_r  <= HALF;
            gap_r    <= {GW{1'b0}};
          end
        end
        HALF: begin
          if (bus.load_ir) begin
            ir_r       <= {shadow_r, bus.data};
            opc_hot_r  <= opc_decode(shadow_r[DW-1 -: 3]);
            ir_valid_r <= 1'b1;
            state_r    <= FULL;
            gap_r      <= {GW{1'b0}};
          end else if (gap_r == GW'(MAX_GAP - 1)) begin
            // Low byte never arrived: drop the orphaned high byte.
            state_r    <= EMPTY;
            frag_err_r <= 1'b1;
            gap_r      <= {GW{1'b0}};
          end else begin
            gap_r <= gap_r + {{(GW-1){1'b0}}, 1'b1};
          end
        end
        FULL: begin
          if (bus.load_ir) begin
            shadow_r   <= bus.data;
            ir_valid_r <= 1'b0;
            state_r    <= HALF;
            gap_r      <= {GW{1'b0}};
          end
        end
        default: begin
          state_r    <= EMPTY;
          ir_valid_r <= 1'b0;
          gap_r      <= {GW{1'b0}};
        end
      endcase
    end
  end

  assign bus.opcode   = ir_r[IR_W-1 -: 3];
  assign bus.ir_addr  = ir_r[AW-1:0];
  assign bus.opc_hot  = opc_hot_r;
  assign bus.ir_valid = ir_valid_r;
  assign bus.frag_err = frag_err_r;

`ifdef IR_HISTORY_EN
  logic            commit_s;
  logic [IR_W-1:0] commit_data_s;

  assign commit_s      = rst && bus.ena && bus.load_ir && (state_r == HALF);
  assign commit_data_s = {shadow_r, bus.data};

  ir_history_buf #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (IR_W)
  ) u_hist (
    .clk   (clk1),
    .rst   (rst),
    .push  (commit_s),
    .wdata (commit_data_s),
    .sel   (bus.hist_sel),
    .rdata (bus.hist_data)
  );
`else
  assign bus.hist_data = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_reg.sv
// Directed scoreboard bench for instr_reg: expectations are queued as stimulus is driven
// and popped against DUT outputs one cycle later.
module tb_instr_reg;
  import risc_pkg::*;

  logic clk1;
  logic rst;
  instr_reg_if bus ();

  instr_reg dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus.slave)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  // Queue the expected visible state after the next stimulus step.
  task automatic expect_state(input logic [2:0] op, input logic [12:0] addr,
                              input logic valid, input logic frag);
    logic [7:0] hot;
    hot = 8'h01 << op;
    push_exp("opcode",   {13'h0000, op});
    push_exp("ir_addr",  {3'h0, addr});
    push_exp("opc_hot",  {8'h00, hot});
    push_exp("ir_valid", {15'h0000, valid});
    push_exp("frag_err", {15'h0000, frag});
  endtask

  task automatic compare(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow observed %h", obs);
    end else begin
      e = sb.pop_front();
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_state();
    compare({13'h0000, bus.opcode});
    compare({3'h0, bus.ir_addr});
    compare({8'h00, bus.opc_hot});
    compare({15'h0000, bus.ir_valid});
    compare({15'h0000, bus.frag_err});
  endtask

  task automatic strobe(input logic [7:0] d);
    bus.load_ir = 1'b1;
    bus.data    = d;
    tick();
    bus.load_ir = 1'b0;
  endtask

  logic [15:0] hist_exp [4];

  initial begin
`ifdef IR_HISTORY_EN
    hist_exp[0] = 16'hA005;
    hist_exp[1] = 16'h8004;
    hist_exp[2] = 16'h6003;
    hist_exp[3] = 16'h4002;
`else
    for (int i = 0; i < 4; i++) hist_exp[i] = 16'h0000;
`endif
    rst          = 1'b0;
    bus.ena      = 1'b1;
    bus.load_ir  = 1'b0;
    bus.data     = 8'h00;
    bus.hist_sel = 2'd0;
    tick();
    tick();

    // Reset state
    expect_state(3'd0, 13'h0000, 1'b0, 1'b0);
    push_exp("hist_reset", 16'h0000);
    tick();
    check_state();
    compare(bus.hist_data);
    rst = 1'b1;

    // First instruction A5,3C -> LDA 053C
    expect_state(LDA, 13'h053C, 1'b1, 1'b0);
    strobe(8'hA5);
    strobe(8'h3C);
    check_state();

    // E0,10 committed, then high byte 41 with a gap before 22
    expect_state(JMP, 13'h0010, 1'b1, 1'b0);
    strobe(8'hE0);
    strobe(8'h10);
    check_state();
    expect_state(JMP, 13'h0010, 1'b0, 1'b0);
    strobe(8'h41);
    check_state();
    expect_state(JMP, 13'h0010, 1'b0, 1'b0);
    tick();
    tick();
    check_state();
    expect_state(ADD, 13'h0122, 1'b1, 1'b0);
    strobe(8'h22);
    check_state();

    // Orphaned high byte 60: timeout after the 6th idle edge
    expect_state(ADD, 13'h0122, 1'b0, 1'b0);
    strobe(8'h60);
    for (int i = 0; i < 5; i++) tick();
    check_state();
    expect_state(ADD, 13'h0122, 1'b0, 1'b1);
    tick();
    check_state();
    expect_state(XORR, 13'h0ABC, 1'b1, 1'b1);
    strobe(8'h8A);
    strobe(8'hBC);
    check_state();

    // ena low while HALF abandons the fetch and ignores that strobe
    expect_state(XORR, 13'h0ABC, 1'b0, 1'b1);
    strobe(8'hC1);
    bus.ena = 1'b0;
    strobe(8'h55);
    bus.ena = 1'b1;
    check_state();
    expect_state(XORR, 13'h0ABC, 1'b0, 1'b1);
    strobe(8'h7F);
    check_state();
    expect_state(ANDD, 13'h1F01, 1'b1, 1'b1);
    strobe(8'h01);
    check_state();

    // Back-to-back strobes: 2 edges commit, the 3rd starts a new fetch
    expect_state(SKZ, 13'h0102, 1'b1, 1'b1);
    bus.load_ir = 1'b1;
    bus.data    = 8'h21;
    tick();
    bus.data    = 8'h02;
    tick();
    check_state();
    expect_state(SKZ, 13'h0102, 1'b0, 1'b1);
    bus.data    = 8'hE3;
    tick();
    bus.load_ir = 1'b0;
    check_state();
    expect_state(JMP, 13'h0304, 1'b1, 1'b1);
    strobe(8'h04);
    check_state();

    // History of five commits
    expect_state(LDA, 13'h0005, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      strobe(8'(k * 32));
      strobe(8'(k));
    end
    check_state();
    for (int s = 0; s < 4; s++) begin
      push_exp($sformatf("hist_sel%0d", s), hist_exp[s]);
      bus.hist_sel = 2'(s);
      #1;
      compare(bus.hist_data);
    end
    bus.hist_sel = 2'd0;

    // Reset mid-fetch coinciding with a strobe
    strobe(8'h12);
    expect_state(HLT, 13'h0000, 1'b0, 1'b0);
    push_exp("hist_after_reset", 16'h0000);
    rst = 1'b0;
    strobe(8'h34);
    check_state();
    compare(bus.hist_data);
    rst = 1'b1;
    expect_state(ADD, 13'h1678, 1'b1, 1'b0);
    strobe(8'h56);
    strobe(8'h78);
    check_state();

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
